if_fetch: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and reads each 32-bit instruction as four byte reads through the memory controller's byte-wide IF port.
- Assembles the bytes little-endian and presents get_inst / if_pc / if_inst to IF/ID.
- Accepts branch redirects from EX and honours the pipeline stall vector.

---
 rtl/if_fetch.sv | 150 +++++++++++++++
 tb/tb_if_fetch.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: fetches each 32-bit instruction as four byte reads
// through the memory controller's byte-wide IF port and assembles them
// little-endian. It presents the result to IF/ID, honours redirects from EX
// and the pipeline stall vector.
// Ports: clk/rst (sync, active-high); stall[0]=PC hold, stall[1]=IF/ID hold;
//   branch_flag_i/branch_target_i redirect; mem_req_o/mem_addr_o/mem_gnt_i/
//   mem_data_i byte port (data one cycle after grant); get_inst/if_pc/if_inst
//   to IF/ID. All outputs are registered.
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_data_i,
  output logic              get_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic [31:0]       if_inst
);

  typedef enum logic {FETCH = 1'b0, DONE = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [2:0]        issue_cnt, issue_n;
  logic [2:0]        recv_cnt, recv_n;
  logic [31:0]       inst_buf, inst_n;
  logic              drop;      // discard the byte returning this cycle
  logic              byte_due;  // a byte was granted last cycle

  logic              grant, byte_ok, last_byte;
  logic              req_n, get_n;
  logic [ADDR_W-1:0] addr_n, if_pc_n;
  logic [31:0]       if_inst_n;

  // Only stall[1:0] concern this stage.
  logic unused_stall;
  assign unused_stall = ^stall[5:2];

  assign grant     = mem_req_o & mem_gnt_i;
  assign byte_ok   = byte_due & ~drop;
  assign last_byte = (state == FETCH) && byte_ok && (recv_cnt == 3'd3);

  // State register and fetch datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      inst_buf  <= '0;
      drop      <= 1'b0;
      // Clearing byte_due drops any byte still in flight across reset.
      byte_due  <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      issue_cnt <= issue_n;
      recv_cnt  <= recv_n;
      inst_buf  <= inst_n;
      drop      <= branch_flag_i & grant;
      byte_due  <= grant;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    issue_n = issue_cnt + {2'b00, grant};
    recv_n  = recv_cnt + {2'b00, byte_ok};
    inst_n  = inst_buf;
    if (state == FETCH && byte_ok)
      inst_n[{recv_cnt[1:0], 3'b000} +: 8] = mem_data_i;
    if (branch_flag_i) begin
      state_n = FETCH;
      pc_n    = branch_target_i;
      issue_n = '0;
      recv_n  = '0;
    end else begin
      case (state)
        FETCH: if (last_byte) state_n = DONE;
        DONE: begin
          if (!stall[1]) begin
            state_n = FETCH;
            pc_n    = pc + PC_STEP;
            issue_n = '0;
            recv_n  = '0;
          end
        end
        default: state_n = FETCH;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    req_n     = 1'b0;
    addr_n    = pc_n + {{(ADDR_W-3){1'b0}}, issue_n};
    get_n     = get_inst;
    if_pc_n   = if_pc;
    if_inst_n = if_inst;
    if (branch_flag_i) begin
      // A redirect kills any held instruction, even one being transferred.
      get_n = 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (last_byte) begin
            get_n     = 1'b1;
            if_pc_n   = pc;
            if_inst_n = inst_n;
          end else if (mem_req_o && !mem_gnt_i) begin
            // An outstanding request is held until granted.
            req_n = 1'b1;
          end else begin
            req_n = (issue_n < 3'd4) && !stall[0];
          end
        end
        DONE: if (!stall[1]) get_n = 1'b0;
        default: get_n = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
      get_inst   <= 1'b0;
      if_pc      <= '0;
      if_inst    <= '0;
    end else begin
      mem_req_o  <= req_n;
      mem_addr_o <= addr_n;
      get_inst   <= get_n;
      if_pc      <= if_pc_n;
      if_inst    <= if_inst_n;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = '0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic [7:0]  mem_data_i = 8'h00;
  logic        get_inst;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  if_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_data_i(mem_data_i),
    .get_inst(get_inst), .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory responder: grants per gnt_en / gnt_toggle, returns the byte the
  // cycle after a grant, and logs every granted address with its cycle.
  logic [7:0]  ram [0:511];
  logic        gnt_en = 1'b0;
  logic        gnt_toggle = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          cyc = 0;
  logic [31:0] addr_q[$];
  int          cyc_q[$];

  always @(negedge clk) begin
    cyc++;
    mem_data_i = pend ? ram[paddr[8:0]] : 8'hEE;
    if (gnt_toggle) mem_gnt_i = ~mem_gnt_i;
    else            mem_gnt_i = gnt_en;
    pend  = mem_req_o && mem_gnt_i;
    paddr = mem_addr_o;
    if (pend) begin
      addr_q.push_back(mem_addr_o);
      cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_get(input int budget, output int c);
    for (int i = 0; i < budget; i++) begin
      step();
      if (get_inst) break;
    end
    c = cyc;
    check("get_timeout", {31'b0, get_inst}, 32'd1);
  endtask

  task automatic check_addrs(input string tag, input logic [31:0] base);
    check({tag, "_n"}, addr_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < addr_q.size()) check(tag, addr_q[i], base + i);
  endtask

  int c;
  int first;
  logic        prev_req, prev_gnt;
  logic [31:0] prev_addr;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'hCC;
    ram[0]   = 8'h13; ram[1]   = 8'h05; ram[2]   = 8'hA0; ram[3]   = 8'h00;
    ram[4]   = 8'h93; ram[5]   = 8'h05; ram[6]   = 8'h10; ram[7]   = 8'h00;
    ram[8]   = 8'h13; ram[9]   = 8'h05; ram[10]  = 8'hA0; ram[11]  = 8'h00;
    ram[256] = 8'hEF; ram[257] = 8'hBE; ram[258] = 8'hAD; ram[259] = 8'hDE;
    ram[508] = 8'h78; ram[509] = 8'h56; ram[510] = 8'h34; ram[511] = 8'h12;

    // Reset state
    step(); step();
    check("rst_get",  {31'b0, get_inst}, 32'd0);
    check("rst_req",  {31'b0, mem_req_o}, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);
    check("rst_pc",   if_pc, 32'd0);
    check("rst_inst", if_inst, 32'd0);

    // Back-to-back grants from address 0
    rst = 1'b0; gnt_en = 1'b1;
    addr_q.delete(); cyc_q.delete();
    wait_get(40, c);
    first = (cyc_q.size() > 0) ? cyc_q[0] : -100;
    check("lat1", c - first, 32'd5);
    check_addrs("addr1", 32'h0);
    if (cyc_q.size() >= 4) check("b2b", cyc_q[3] - cyc_q[0], 32'd3);
    check("inst1", if_inst, 32'h00A00513);
    check("pc1",   if_pc, 32'h0);

    // IF/ID stall holds the instruction for three cycles
    stall = 6'b000010; addr_q.delete();
    for (int i = 0; i < 3; i++) begin
      check("hold_get",  {31'b0, get_inst}, 32'd1);
      check("hold_pc",   if_pc, 32'h0);
      check("hold_inst", if_inst, 32'h00A00513);
      check("hold_req",  {31'b0, mem_req_o}, 32'd0);
      step();
    end
    stall = 6'b0;
    step();
    check("xfer_get", {31'b0, get_inst}, 32'd0);
    wait_get(40, c);
    check_addrs("addr2", 32'h4);
    check("inst2", if_inst, 32'h00100593);
    check("pc2",   if_pc, 32'h4);

    // Toggling grant: address and request held while ungranted
    gnt_toggle = 1'b1; addr_q.delete();
    for (int i = 0; i < 60; i++) begin
      prev_req = mem_req_o; prev_gnt = mem_gnt_i; prev_addr = mem_addr_o;
      step();
      if (prev_req && !prev_gnt) begin
        check("tog_req",  {31'b0, mem_req_o}, 32'd1);
        check("tog_addr", mem_addr_o, prev_addr);
      end
      if (get_inst) break;
    end
    check("tog_done", {31'b0, get_inst}, 32'd1);
    check_addrs("addr3", 32'h8);
    check("inst3", if_inst, 32'h00A00513);
    check("pc3",   if_pc, 32'h8);

    // Redirect the cycle after byte 1 is granted
    gnt_toggle = 1'b0; gnt_en = 1'b1; addr_q.delete();
    for (int i = 0; i < 20; i++) begin
      step();
      if (addr_q.size() >= 2) break;
    end
    step();
    branch_flag_i = 1'b1; branch_target_i = 32'h100;
    step();
    branch_flag_i = 1'b0;
    check("br_req", {31'b0, mem_req_o}, 32'd0);
    check("br_get", {31'b0, get_inst}, 32'd0);
    check("br_ngr", addr_q.size(), 32'd3);
    addr_q.delete();
    wait_get(40, c);
    check_addrs("addr4", 32'h100);
    check("inst4", if_inst, 32'hDEADBEEF);
    check("pc4",   if_pc, 32'h100);

    // Redirect while DONE, to the top of the address space
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
    step();
    branch_flag_i = 1'b0;
    check("brd_get", {31'b0, get_inst}, 32'd0);
    check("brd_req", {31'b0, mem_req_o}, 32'd0);
    addr_q.delete();
    wait_get(40, c);
    check_addrs("addr5", 32'hFFFF_FFFC);
    check("inst5", if_inst, 32'h12345678);
    check("pc5",   if_pc, 32'hFFFF_FFFC);

    // PC hold: transfer still happens, new requests are suppressed
    stall = 6'b000001; addr_q.delete();
    step();
    check("s0_get", {31'b0, get_inst}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("s0_req", {31'b0, mem_req_o}, 32'd0);
      step();
    end
    stall = 6'b0;
    wait_get(40, c);
    check_addrs("addr6", 32'h0);
    check("inst6", if_inst, 32'h00A00513);
    check("pc6",   if_pc, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
